// File: rtl/key_debounce_multi_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
// Defining KEY_DEBOUNCE_MULTI_LONG_PRESS_EN adds long-press/auto-repeat pulses.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } key_state_t;

   localparam logic KEY_PRESSED = 1'b0;

   // A counter holding values 0..n-1 needs at least one bit, even for tiny n.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_debounce_multi_chan.sv
// One debounced key channel: synchroniser, filter FSM, level and event pulses.
// Long-press/repeat logic exists only with KEY_DEBOUNCE_MULTI_LONG_PRESS_EN defined.
module key_deb_chan
   import key_pkg::*;
#(
   parameter int DEB_CYCLES    = 1_000_000,
   parameter int SYNC_STAGES   = 2,
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n_i,
   output logic deb_key_n_o,
   output logic press_pulse_o,
   output logic release_pulse_o,
   output logic long_pulse_o
);

   localparam int CW = cnt_width(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   keyS;
   key_state_t             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   deb_q, deb_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;

   assign keyS = sync_q[SYNC_STAGES-1];

   // Synchroniser, state and registered outputs share one reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= '1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         deb_q     <= 1'b1;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], key_n_i};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         deb_q     <= deb_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // A level change is accepted only after DEB_CYCLES further stable samples.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      deb_d     = deb_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (keyS == KEY_PRESSED) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (keyS != KEY_PRESSED) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               deb_d   = KEY_PRESSED;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (keyS != KEY_PRESSED) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (keyS == KEY_PRESSED) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               cnt_d     = '0;
               deb_d     = ~KEY_PRESSED;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign deb_key_n_o     = deb_q;
   assign press_pulse_o   = press_q;
   assign release_pulse_o = release_q;

`ifdef KEY_DEBOUNCE_MULTI_LONG_PRESS_EN
   localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int HW   = cnt_width(HMAX + 1);

   logic [HW-1:0] holdCnt_q, holdCnt_d;
   logic          longDone_q, longDone_d;
   logic          long_q, long_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         holdCnt_q  <= '0;
         longDone_q <= 1'b0;
         long_q     <= 1'b0;
      end else begin
         holdCnt_q  <= holdCnt_d;
         longDone_q <= longDone_d;
         long_q     <= long_d;
      end
   end

   // After the first long pulse the counter restarts to time the repeat interval;
   // it freezes during a release bounce so a bounce-back resumes the hold.
   always_comb begin
      holdCnt_d  = holdCnt_q;
      longDone_d = longDone_q;
      long_d     = 1'b0;
      if (state_q == IDLE || (state_q == PRESS_WAIT && state_d == PRESSED)) begin
         holdCnt_d  = '0;
         longDone_d = 1'b0;
      end else if (state_q == PRESSED && keyS == KEY_PRESSED) begin
         if (!longDone_q) begin
            if (holdCnt_q == HW'(LONG_CYCLES - 2)) begin
               long_d     = 1'b1;
               longDone_d = 1'b1;
               holdCnt_d  = '0;
            end else begin
               holdCnt_d = holdCnt_q + 1'b1;
            end
         end else if (REPEAT_CYCLES > 0) begin
            if (holdCnt_q == HW'(REPEAT_CYCLES - 1)) begin
               long_d    = 1'b1;
               holdCnt_d = '0;
            end else begin
               holdCnt_d = holdCnt_q + 1'b1;
            end
         end
      end
   end

   assign long_pulse_o = long_q;
`else
   assign long_pulse_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// N independent debounced key channels, all outputs in the clk domain.
// Optional long-press/repeat events: define KEY_DEBOUNCE_MULTI_LONG_PRESS_EN.
module key_debounce_multi
   import key_pkg::*;
#(
   parameter int NUM_KEYS      = 4,
   parameter int DEB_CYCLES    = 1_000_000,
   parameter int SYNC_STAGES   = 2,
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] deb_key_n,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse,
   output logic [NUM_KEYS-1:0] long_pulse
);

   for (genvar g = 0; g < NUM_KEYS; g++) begin : gChan
      key_deb_chan #(
         .DEB_CYCLES   (DEB_CYCLES),
         .SYNC_STAGES  (SYNC_STAGES),
         .LONG_CYCLES  (LONG_CYCLES),
         .REPEAT_CYCLES(REPEAT_CYCLES)
      ) uChan (
         .clk            (clk),
         .rst            (rst),
         .key_n_i        (key_n[g]),
         .deb_key_n_o    (deb_key_n[g]),
         .press_pulse_o  (press_pulse[g]),
         .release_pulse_o(release_pulse[g]),
         .long_pulse_o   (long_pulse[g])
      );
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: per-cycle model comparison plus literal checkpoints.
// Long-press expectations follow KEY_DEBOUNCE_MULTI_LONG_PRESS_EN.
module tb_key_debounce_multi;

   localparam int NK     = 4;
   localparam int DEB    = 4;
   localparam int SYNC   = 2;
   localparam int LONG   = 20;
   localparam int REPEAT = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NK-1:0] key_n = '1;
   logic [NK-1:0] deb_key_n, press_pulse, release_pulse, long_pulse;

   int total = 0;
   int bad   = 0;
   bit checkEn = 1'b0;

   key_debounce_multi #(
      .NUM_KEYS(NK), .DEB_CYCLES(DEB), .SYNC_STAGES(SYNC),
      .LONG_CYCLES(LONG), .REPEAT_CYCLES(REPEAT)
   ) dut (
      .clk(clk), .rst(rst), .key_n(key_n), .deb_key_n(deb_key_n),
      .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse)
   );

   always #5 clk = ~clk;

   // Model: a level flips once the synchronised key has disagreed with it for DEB+1
   // consecutive samples; hold age counts stable pressed cycles since the press event.
   logic [NK-1:0] hist [SYNC];
   logic [NK-1:0] expDeb = '1, expPress = '0, expRelease = '0, expLong = '0;
   int runLen [NK];
   int age [NK];

   always @(posedge clk) begin
      logic [NK-1:0] sample;
      bit stableBefore;
      if (rst) begin
         for (int s = 0; s < SYNC; s++) hist[s] = '1;
         expDeb = '1; expPress = '0; expRelease = '0; expLong = '0;
         for (int k = 0; k < NK; k++) begin runLen[k] = 0; age[k] = 0; end
      end else begin
         sample = hist[SYNC-1];
         for (int s = SYNC-1; s > 0; s--) hist[s] = hist[s-1];
         hist[0] = key_n;
         expPress = '0; expRelease = '0; expLong = '0;
         for (int k = 0; k < NK; k++) begin
            stableBefore = (runLen[k] == 0);
            if (sample[k] != expDeb[k]) begin
               runLen[k]++;
               if (runLen[k] == DEB + 1) begin
                  runLen[k] = 0;
                  age[k] = 0;
                  if (expDeb[k]) expPress[k] = 1'b1; else expRelease[k] = 1'b1;
                  expDeb[k] = ~expDeb[k];
               end
            end else begin
               runLen[k] = 0;
`ifdef KEY_DEBOUNCE_MULTI_LONG_PRESS_EN
               if (!expDeb[k] && stableBefore) begin
                  age[k]++;
                  if (age[k] == LONG - 1 ||
                      (REPEAT > 0 && age[k] > LONG - 1 && (age[k] - (LONG - 1)) % REPEAT == 0))
                     expLong[k] = 1'b1;
               end
`endif
            end
         end
      end
   end

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (checkEn) begin
         total++;
         if (deb_key_n !== expDeb) begin
            bad++;
            $display("[TB] FAIL cyc_deb at %0t: got %b want %b", $time, deb_key_n, expDeb);
         end
         total++;
         if (press_pulse !== expPress) begin
            bad++;
            $display("[TB] FAIL cyc_press at %0t: got %b want %b", $time, press_pulse, expPress);
         end
         total++;
         if (release_pulse !== expRelease) begin
            bad++;
            $display("[TB] FAIL cyc_release at %0t: got %b want %b", $time, release_pulse, expRelease);
         end
         total++;
         if (long_pulse !== expLong) begin
            bad++;
            $display("[TB] FAIL cyc_long at %0t: got %b want %b", $time, long_pulse, expLong);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic r, input logic [NK-1:0] k, input int cycles);
      rst   = r;
      key_n = k;
      tick(cycles);
   endtask

   task automatic checkOutput(input string name, input logic [NK-1:0] got, input logic [NK-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   initial begin
      applyStimulus(1'b1, 4'hF, 3);
      checkEn = 1'b1;
      checkOutput("reset_deb", deb_key_n, 4'hF);
      checkOutput("reset_press", press_pulse, 4'h0);

      // Clean press on key 0: pulse appears after edge 6.
      applyStimulus(1'b0, 4'hF, 2);
      applyStimulus(1'b0, 4'b1110, 6);
      checkOutput("clean_before", press_pulse, 4'b0000);
      tick(1);
      checkOutput("clean_press", press_pulse, 4'b0001);
      checkOutput("clean_deb", deb_key_n, 4'b1110);
      tick(1);
      checkOutput("clean_single", press_pulse, 4'b0000);

      // Key 1 bounce: 3 low, 1 high, then low for good.
      applyStimulus(1'b0, 4'b1100, 3);
      applyStimulus(1'b0, 4'b1110, 1);
      applyStimulus(1'b0, 4'b1100, 6);
      checkOutput("bounce_early", press_pulse, 4'b0000);
      tick(1);
      checkOutput("bounce_press", press_pulse, 4'b0010);

      // Key 2 press, then release bounce-back, then real release.
      applyStimulus(1'b0, 4'b1000, 8);
      applyStimulus(1'b0, 4'b1100, 2);
      applyStimulus(1'b0, 4'b1000, 8);
      checkOutput("bb_deb", deb_key_n, 4'b1000);
      applyStimulus(1'b0, 4'b1100, 7);
      checkOutput("rel_pulse", release_pulse, 4'b0100);
      checkOutput("rel_deb", deb_key_n, 4'b1100);

      // Simultaneous press and release of all keys.
      applyStimulus(1'b0, 4'hF, 10);
      checkOutput("idle_all", deb_key_n, 4'hF);
      applyStimulus(1'b0, 4'h0, 7);
      checkOutput("sim_press", press_pulse, 4'hF);
      applyStimulus(1'b0, 4'hF, 7);
      checkOutput("sim_release", release_pulse, 4'hF);
      tick(4);

      // Long press on key 3: offset 0 is the press_pulse cycle.
      applyStimulus(1'b0, 4'b0111, 7);
      checkOutput("long_press", press_pulse, 4'b1000);
      for (int off = 1; off <= 40; off++) begin
         logic [NK-1:0] want;
         tick(1);
         want = '0;
`ifdef KEY_DEBOUNCE_MULTI_LONG_PRESS_EN
         if (off == 19 || off == 27 || off == 35) want = 4'b1000;
`endif
         checkOutput($sformatf("long_off%0d", off), long_pulse, want);
      end
      applyStimulus(1'b0, 4'hF, 20);

      // Reset mid PRESS_WAIT (cnt=2) then a fresh full-latency press.
      applyStimulus(1'b0, 4'b1110, 5);
      applyStimulus(1'b1, 4'b1110, 1);
      checkOutput("rstpw_deb", deb_key_n, 4'hF);
      checkOutput("rstpw_press", press_pulse, 4'h0);
      applyStimulus(1'b0, 4'b1110, 6);
      checkOutput("fresh_early", press_pulse, 4'h0);
      tick(1);
      checkOutput("fresh_press", press_pulse, 4'b0001);

      // Reset while PRESSED discards the level without a release pulse.
      tick(3);
      applyStimulus(1'b1, 4'b1110, 1);
      checkOutput("rstp_deb", deb_key_n, 4'hF);
      checkOutput("rstp_release", release_pulse, 4'h0);
      applyStimulus(1'b0, 4'hF, 10);

      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
